// File: rtl/crc_sched.sv
// crc_sched: shares a single CRC engine between NUM_REQ requesters.
//
// A round-robin arbiter picks one pending requester while idle. Its payload
// is registered and handed to the engine with a one-cycle start pulse. The
// scheduler then waits for the engine's done pulse, or gives up after
// TIMEOUT cycles. The result, or an error, is held on the response port
// until the consumer accepts it.
//
// Ports
//   clk, rst_n   clock; asynchronous active-low reset
//   req_valid    per-requester pending request (level sensitive)
//   req_data     packed payloads, requester i at [i*DATA_W +: DATA_W]
//   req_ready    one-hot accept strobe, combinational, only while idle
//   eng_valid    one-cycle start pulse to the engine
//   eng_data     registered payload, stable while the engine works
//   eng_crc      engine result, sampled on eng_done
//   eng_done     engine completion pulse, honoured only while waiting
//   rsp_valid    result available
//   rsp_ready    consumer accepts result
//   rsp_id       requester index that owns the result
//   rsp_crc      CRC result (0 on error)
//   rsp_err      engine timed out
//   busy         scheduler is not idle
module crc_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 256,
    parameter int TIMEOUT = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       eng_valid,
    output logic [DATA_W-1:0]          eng_data,
    input  logic [31:0]                eng_crc,
    input  logic                       eng_done,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id,
    output logic [31:0]                rsp_crc,
    output logic                       rsp_err,
    output logic                       busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic [1:0]       state;
    logic [ID_W-1:0]  last_grant;
    logic [CNT_W-1:0] cnt;
    logic [ID_W-1:0]  winner;
    logic [ID_W-1:0]  idx;
    logic             found;

    // Round-robin search: start just past the last grant and wrap around.
    // The first pending requester found wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The accept strobe is qualified with rst_n so it stays low during reset,
    // even though the state register already reads IDLE at that point.
    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_ready
            assign req_ready[g] = rst_n && (state == S_IDLE) && found &&
                                  (winner == ID_W'(g));
        end
    endgenerate

    assign eng_valid = (state == S_LAUNCH);
    assign rsp_valid = (state == S_RESP);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            last_grant <= ID_W'(NUM_REQ - 1);
            cnt        <= '0;
            eng_data   <= '0;
            rsp_id     <= '0;
            rsp_crc    <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (found) begin
                        eng_data   <= req_data[winner*DATA_W +: DATA_W];
                        rsp_id     <= winner;
                        last_grant <= winner;
                        state      <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    cnt   <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    // When done and timeout coincide, done wins and the
                    // real result is kept.
                    if (eng_done) begin
                        rsp_crc <= eng_crc;
                        rsp_err <= 1'b0;
                        state   <= S_RESP;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        rsp_crc <= '0;
                        rsp_err <= 1'b1;
                        state   <= S_RESP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    // Going back to IDLE here means no grant can happen in
                    // the same cycle as the handshake.
                    if (rsp_ready) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_sched.sv
module tb_crc_sched;

    localparam int NR = 4;
    localparam int DW = 256;
    localparam int TO = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     req_ready;
    logic              eng_valid;
    logic [DW-1:0]     eng_data;
    logic [31:0]       eng_crc;
    logic              eng_done;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_crc;
    logic              rsp_err;
    logic              busy;

    int n_pass = 0;
    int n_tot  = 0;
    int mlast;          // reference model: last granted requester
    int eng_lat = 0;    // engine model: done in WAIT cycle eng_lat-1; 0 = never

    crc_sched #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .eng_valid(eng_valid), .eng_data(eng_data),
        .eng_crc(eng_crc), .eng_done(eng_done),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_crc(rsp_crc), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Standard reflected CRC-32, payload consumed least-significant byte first.
    function automatic logic [31:0] crc32(input logic [DW-1:0] d);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        for (int b = 0; b < DW / 8; b++) begin
            c = c ^ {24'h0, d[8*b +: 8]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic int pick(input logic [NR-1:0] mask);
        for (int k = 1; k <= NR; k++)
            if (mask[(mlast + k) % NR]) return (mlast + k) % NR;
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Engine model: reacts to the start pulse and returns the CRC of the
    // payload it was handed, after eng_lat cycles.
    always begin : engine
        logic [DW-1:0] cap;
        @(negedge clk);
        if (eng_valid === 1'b1 && eng_lat > 0) begin
            cap = eng_data;
            repeat (eng_lat) @(negedge clk);
            eng_crc  = crc32(cap);
            eng_done = 1'b1;
            @(negedge clk);
            eng_done = 1'b0;
            eng_crc  = $urandom;
        end
    end

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_req_ready"}, req_ready, '0);
        chk({pfx, "_eng_valid"}, eng_valid, 0);
        chk({pfx, "_eng_data"},  eng_data,  '0);
        chk({pfx, "_rsp_valid"}, rsp_valid, 0);
        chk({pfx, "_rsp_id"},    rsp_id,    0);
        chk({pfx, "_rsp_crc"},   rsp_crc,   0);
        chk({pfx, "_rsp_err"},   rsp_err,   0);
        chk({pfx, "_busy"},      busy,      0);
    endtask

    // One transaction, starting at a negedge in IDLE with req_valid already
    // driven. Ends at the negedge where the scheduler is back in IDLE.
    task automatic run_txn(input int lat, input int bp,
                           output logic [NR-1:0] gnt, output logic [31:0] crc_obs);
        logic [DW-1:0] exp_d;
        logic [31:0]   exp_crc;
        logic          exp_err;
        int            w, n, n_exp;
        bit            bad;
        w = pick(req_valid);
        eng_lat = lat;
        crc_obs = '0;
        #1;
        gnt = req_ready;
        chk("grant", req_ready, NR'(1) << w);
        exp_d = req_data[w*DW +: DW];
        if (lat >= 1 && lat <= TO) begin
            exp_crc = crc32(exp_d); exp_err = 1'b0; n_exp = lat + 1;
        end else begin
            exp_crc = '0; exp_err = 1'b1; n_exp = TO + 1;
        end
        mlast = w;
        @(negedge clk);
        chk("launch_eng_valid", eng_valid, 1);
        chk("launch_eng_data", eng_data, exp_d);
        chk("launch_req_ready", req_ready, 0);
        n = 0; bad = 0;
        while (rsp_valid !== 1'b1 && n < TO + 8) begin
            @(negedge clk);
            n++;
            if (rsp_valid !== 1'b1 &&
                (eng_valid !== 1'b0 || eng_data !== exp_d || req_ready !== '0 || busy !== 1'b1))
                bad = 1;
        end
        chk("rsp_latency", n, n_exp);
        chk("wait_stable", bad, 0);
        if (rsp_valid === 1'b1) begin
            crc_obs = rsp_crc;
            chk("rsp_id", rsp_id, w);
            chk("rsp_crc", rsp_crc, exp_crc);
            chk("rsp_err", rsp_err, exp_err);
            bad = 0;
            repeat (bp) begin
                @(negedge clk);
                if (rsp_valid !== 1'b1 || int'(rsp_id) != w || rsp_crc !== exp_crc ||
                    rsp_err !== exp_err || req_ready !== '0 || busy !== 1'b1)
                    bad = 1;
            end
            chk("resp_hold", bad, 0);
            rsp_ready = 1'b1;
            #1;
            chk("no_grant_on_accept", req_ready, 0);
            @(negedge clk);
            rsp_ready = 1'b0;
            chk("rsp_valid_fall", rsp_valid, 0);
            chk("idle_busy", busy, 0);
        end
    endtask

    task automatic fill_random();
        for (int j = 0; j < NR * DW / 32; j++) req_data[32*j +: 32] = $urandom;
    endtask

    initial begin
        logic [NR-1:0] gnt;
        logic [31:0]   cobs;
        int            order [5] = '{0, 1, 2, 3, 0};
        bit            bad;
        int            lat;

        rst_n = 1'b0; rsp_ready = 1'b0; eng_done = 1'b0; eng_crc = '0;
        req_valid = '1; fill_random();
        mlast = NR - 1;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // Fairness, starting straight out of reset: 0,1,2,3,0
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fill_random();
            run_txn(2 + k, 0, gnt, cobs);
            chk("fair_order", gnt, NR'(1) << order[k]);
        end

        // Single request, all-zero payload
        req_valid = 4'b0001; req_data = '0;
        run_txn(3, 0, gnt, cobs);
        chk("single_crc", cobs, 32'h190A_55AD);

        // Timeout: engine silent
        req_valid = 4'b0100; fill_random();
        run_txn(0, 0, gnt, cobs);

        // Done in the same cycle as the timeout
        req_valid = 4'b1010; fill_random();
        run_txn(TO, 0, gnt, cobs);

        // Done one cycle too late: still a timeout, and the late pulse is ignored
        req_valid = 4'b0011; fill_random();
        run_txn(TO + 1, 0, gnt, cobs);

        // Backpressure for 10 cycles
        req_valid = 4'b1111; fill_random();
        run_txn(4, 10, gnt, cobs);

        // eng_done pulse while idle is ignored
        req_valid = '0;
        eng_done = 1'b1; eng_crc = 32'hDEAD_BEEF;
        @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        chk("idle_done_busy", busy, 0);
        chk("idle_done_rsp_valid", rsp_valid, 0);

        // Randomized traffic
        for (int t = 0; t < 25; t++) begin
            req_valid = NR'($urandom_range(1, (1 << NR) - 1));
            fill_random();
            lat = ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, TO + 1));
            run_txn(lat, int'($urandom_range(0, 3)), gnt, cobs);
        end

        // Reset in the middle of WAIT
        req_valid = 4'b0010; fill_random(); eng_lat = 0;
        @(negedge clk);   // LAUNCH
        repeat (3) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midwait_reset");
        req_valid = '0;
        mlast = NR - 1;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1;
        end
        chk("no_stale_rsp", bad, 0);
        req_valid = 4'b1111; fill_random();
        run_txn(2, 0, gnt, cobs);
        chk("post_reset_grant0", gnt, 4'b0001);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
